hazard_ctrl: RTL and testbench

Pipeline control unit for the five-stage RV32I core. It tracks the destination registers of the instructions in EX, MEM and WB, and generates per-stage stall and flush controls, operand forwarding selects for the EX-stage ALU operands, and the branch/jump redirect. It sits beside the EX stage and consumes the branch unit's PC-select code.

---
 rtl/hazard_pkg.sv | 20 ++
 rtl/hazard_ctrl_reg_match.sv | 18 +
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard control unit.
// Forward-select encoding, PC-select constant and scoreboard entry.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] PCSEL_SEQ = 2'b00;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
    } sb_entry_t;

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// reg_match: does a used source register hit a live scoreboard entry.
// x0 never matches, so it can never stall or forward.
module reg_match
    import hazard_pkg::*;
(
    input  logic [4:0] i_reg,
    input  logic       i_use,
    input  sb_entry_t  i_entry,
    output logic       o_match
);

    assign o_match = i_use
                   & i_entry.valid
                   & i_entry.regwrite
                   & (i_entry.rd != 5'd0)
                   & (i_entry.rd == i_reg);

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward/redirect control for the 5-stage core.
// Tracks EX/MEM/WB destinations in a three-entry scoreboard.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int FWD_EN = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_id_valid,
    input  logic [4:0]  i_id_rs1,
    input  logic [4:0]  i_id_rs2,
    input  logic        i_id_use_rs1,
    input  logic        i_id_use_rs2,
    input  logic [4:0]  i_id_rd,
    input  logic        i_id_regwrite,
    input  logic        i_id_memread,
    input  logic [1:0]  i_ex_pc_select,
    input  logic [31:0] i_ex_target,
    input  logic        i_mem_busy,
    output logic        o_stall_if,
    output logic        o_stall_id,
    output logic        o_flush_id,
    output logic        o_flush_ex,
    output logic [1:0]  o_fwd_op1,
    output logic [1:0]  o_fwd_op2,
    output logic        o_redirect,
    output logic [31:0] o_redirect_pc
);

    localparam bit FWD_ON = (FWD_EN != 0);

    sb_entry_t  ex_q, ex_d;
    sb_entry_t  mem_q, mem_d;
    sb_entry_t  wb_q, wb_d;
    logic [4:0] ex_rs1_q, ex_rs1_d;
    logic [4:0] ex_rs2_q, ex_rs2_d;
    logic       ex_use1_q, ex_use1_d;
    logic       ex_use2_q, ex_use2_d;

    logic id_use1, id_use2;
    logic id1_ex, id2_ex, id1_mem, id2_mem;
    logic ex1_mem, ex2_mem, ex1_wb, ex2_wb;
    logic load_use, raw_stall, freeze, redirect;
    fwd_sel_t fwd1, fwd2;

    // An empty ID slot never asks for operands
    assign id_use1 = i_id_use_rs1 & i_id_valid;
    assign id_use2 = i_id_use_rs2 & i_id_valid;

    reg_match u_id1_ex (
        .i_reg(i_id_rs1), .i_use(id_use1),
        .i_entry(ex_q), .o_match(id1_ex));
    reg_match u_id2_ex (
        .i_reg(i_id_rs2), .i_use(id_use2),
        .i_entry(ex_q), .o_match(id2_ex));
    reg_match u_id1_mem (
        .i_reg(i_id_rs1), .i_use(id_use1),
        .i_entry(mem_q), .o_match(id1_mem));
    reg_match u_id2_mem (
        .i_reg(i_id_rs2), .i_use(id_use2),
        .i_entry(mem_q), .o_match(id2_mem));
    reg_match u_ex1_mem (
        .i_reg(ex_rs1_q), .i_use(ex_use1_q),
        .i_entry(mem_q), .o_match(ex1_mem));
    reg_match u_ex2_mem (
        .i_reg(ex_rs2_q), .i_use(ex_use2_q),
        .i_entry(mem_q), .o_match(ex2_mem));
    reg_match u_ex1_wb (
        .i_reg(ex_rs1_q), .i_use(ex_use1_q),
        .i_entry(wb_q), .o_match(ex1_wb));
    reg_match u_ex2_wb (
        .i_reg(ex_rs2_q), .i_use(ex_use2_q),
        .i_entry(wb_q), .o_match(ex2_wb));

    // Hazard classification; reset masks everything to idle
    always_comb begin
        load_use  = (id1_ex | id2_ex) & ex_q.memread;
        raw_stall = !FWD_ON
                  & (id1_ex | id2_ex | id1_mem | id2_mem);
        freeze    = i_mem_busy & ~i_rst;
        redirect  = ex_q.valid & ~i_mem_busy & ~i_rst
                  & (i_ex_pc_select != PCSEL_SEQ);
    end

    // Forward selects: the younger MEM result wins over WB
    always_comb begin
        fwd1 = FWD_RF;
        fwd2 = FWD_RF;
        if (FWD_ON) begin
            if (ex1_mem)     fwd1 = FWD_EXMEM;
            else if (ex1_wb) fwd1 = FWD_MEMWB;
            if (ex2_mem)     fwd2 = FWD_EXMEM;
            else if (ex2_wb) fwd2 = FWD_MEMWB;
        end
    end

    // Control outputs: freeze > redirect > load-use/RAW stall
    always_comb begin
        o_stall_if    = 1'b0;
        o_stall_id    = 1'b0;
        o_flush_id    = 1'b0;
        o_flush_ex    = 1'b0;
        o_redirect    = 1'b0;
        o_redirect_pc = i_ex_target;
        o_fwd_op1     = i_rst ? FWD_RF : fwd1;
        o_fwd_op2     = i_rst ? FWD_RF : fwd2;
        if (freeze) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
        end else if (redirect) begin
            o_redirect = 1'b1;
            o_flush_id = 1'b1;
            o_flush_ex = 1'b1;
        end else if ((load_use | raw_stall) & ~i_rst) begin
            o_stall_if = 1'b1;
            o_stall_id = 1'b1;
            o_flush_ex = 1'b1;
        end
    end

    // Scoreboard advance; a flushed EX slot becomes a bubble
    always_comb begin
        ex_d      = ex_q;
        mem_d     = mem_q;
        wb_d      = wb_q;
        ex_rs1_d  = ex_rs1_q;
        ex_rs2_d  = ex_rs2_q;
        ex_use1_d = ex_use1_q;
        ex_use2_d = ex_use2_q;
        if (!i_mem_busy) begin
            ex_d.valid    = i_id_valid & ~o_flush_ex;
            ex_d.rd       = i_id_rd;
            ex_d.regwrite = i_id_regwrite;
            ex_d.memread  = i_id_memread;
            ex_rs1_d      = i_id_rs1;
            ex_rs2_d      = i_id_rs2;
            ex_use1_d     = i_id_use_rs1 & ex_d.valid;
            ex_use2_d     = i_id_use_rs2 & ex_d.valid;
            mem_d         = ex_q;
            wb_d          = mem_q;
        end
    end

    // Scoreboard state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            ex_rs1_q  <= '0;
            ex_rs2_q  <= '0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl, forwarding and
// stall-only variants side by side on shared inputs.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic        id_u1 = 1'b0, id_u2 = 1'b0;
    logic        id_rw = 1'b0, id_mr = 1'b0;
    logic [1:0]  pcsel = '0;
    logic [31:0] target = '0;
    logic        busy = 1'b0;

    logic        a_sif, a_sid, a_fid, a_fex, a_red;
    logic [1:0]  a_f1, a_f2;
    logic [31:0] a_pc;
    logic        b_sif, b_sid, b_fid, b_fex, b_red;
    logic [1:0]  b_f1, b_f2;
    logic [31:0] b_pc;

    int vectors = 0;
    int miscompares = 0;

    logic [40:0] exp_q[$];
    bit          sel_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.FWD_EN(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_u1), .i_id_use_rs2(id_u2),
        .i_id_rd(id_rd), .i_id_regwrite(id_rw),
        .i_id_memread(id_mr), .i_ex_pc_select(pcsel),
        .i_ex_target(target), .i_mem_busy(busy),
        .o_stall_if(a_sif), .o_stall_id(a_sid),
        .o_flush_id(a_fid), .o_flush_ex(a_fex),
        .o_fwd_op1(a_f1), .o_fwd_op2(a_f2),
        .o_redirect(a_red), .o_redirect_pc(a_pc));

    hazard_ctrl #(.FWD_EN(0)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
        .i_id_rs1(id_rs1), .i_id_rs2(id_rs2),
        .i_id_use_rs1(id_u1), .i_id_use_rs2(id_u2),
        .i_id_rd(id_rd), .i_id_regwrite(id_rw),
        .i_id_memread(id_mr), .i_ex_pc_select(pcsel),
        .i_ex_target(target), .i_mem_busy(busy),
        .o_stall_if(b_sif), .o_stall_id(b_sid),
        .o_flush_id(b_fid), .o_flush_ex(b_fex),
        .o_fwd_op1(b_f1), .o_fwd_op2(b_f2),
        .o_redirect(b_red), .o_redirect_pc(b_pc));

    function automatic logic [40:0] mk(
        bit si, bit sd, bit fi, bit fe,
        logic [1:0] f1, logic [1:0] f2,
        bit rd, logic [31:0] pc);
        return {si, sd, fi, fe, f1, f2, rd, pc};
    endfunction

    task automatic id(bit v, logic [4:0] r1, bit u1,
                      logic [4:0] r2, bit u2,
                      logic [4:0] rd, bit rw, bit mr);
        id_valid = v;
        id_rs1 = r1; id_u1 = u1;
        id_rs2 = r2; id_u2 = u2;
        id_rd = rd; id_rw = rw; id_mr = mr;
    endtask

    task automatic nop();
        id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // expectation is queued with the stimulus, compared once settled
    task automatic chk(string tag, bit sel, logic [40:0] e);
        logic [40:0] obs, exp_v;
        bit s;
        string t;
        exp_q.push_back(e);
        sel_q.push_back(sel);
        tag_q.push_back(tag);
        #2;
        exp_v = exp_q.pop_front();
        s = sel_q.pop_front();
        t = tag_q.pop_front();
        if (s)
            obs = {b_sif, b_sid, b_fid, b_fex, b_f1, b_f2, b_red, b_pc};
        else
            obs = {a_sif, a_sid, a_fid, a_fex, a_f1, a_f2, a_red, a_pc};
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", t, obs, exp_v);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nop();
        pcsel = 2'b00; target = '0; busy = 1'b0;
        rst = 1'b1;
        edge_step();
        rst = 1'b0;
    endtask

    localparam logic [40:0] IDLE = '0;

    initial begin
        // reset state
        target = 32'h55;
        #2;
        chk("rst_a", 0, mk(0,0,0,0,2'b00,2'b00,0,32'h55));
        chk("rst_b", 1, mk(0,0,0,0,2'b00,2'b00,0,32'h55));
        do_reset();

        // RAW with forwarding: addi x5 ; add x6,x5,x5
        id(1, 0, 1, 0, 0, 5, 1, 0);
        chk("fwd_c1", 0, IDLE);
        edge_step();
        id(1, 5, 1, 5, 1, 6, 1, 0);
        chk("fwd_c2_nostall", 0, IDLE);
        edge_step();
        nop();
        chk("fwd_c3_exmem", 0, mk(0,0,0,0,2'b01,2'b01,0,0));

        // load-use: lw x7 ; add x8,x7,x0
        do_reset();
        id(1, 2, 1, 0, 0, 7, 1, 1);
        chk("lu_c1", 0, IDLE);
        edge_step();
        id(1, 7, 1, 0, 1, 8, 1, 0);
        chk("lu_stall", 0, mk(1,1,0,1,2'b00,2'b00,0,0));
        edge_step();
        chk("lu_release", 0, IDLE);
        edge_step();
        nop();
        chk("lu_fwd_memwb", 0, mk(0,0,0,0,2'b10,2'b00,0,0));

        // x0 destination: lw x0 ; add x1,x0,x0
        do_reset();
        id(1, 2, 1, 0, 0, 0, 1, 1);
        chk("x0_c1", 0, IDLE);
        edge_step();
        id(1, 0, 1, 0, 1, 1, 1, 0);
        chk("x0_nostall", 0, IDLE);
        edge_step();
        nop();
        chk("x0_nofwd", 0, IDLE);

        // redirect held off by a busy memory
        do_reset();
        id(1, 0, 0, 0, 0, 1, 1, 0);
        chk("br_c1", 0, IDLE);
        edge_step();
        id(1, 3, 1, 4, 1, 9, 1, 0);
        pcsel = 2'b01; target = 32'h100; busy = 1'b1;
        chk("br_busy1", 0, mk(1,1,0,0,2'b00,2'b00,0,32'h100));
        edge_step();
        chk("br_busy2", 0, mk(1,1,0,0,2'b00,2'b00,0,32'h100));
        edge_step();
        chk("br_busy3", 0, mk(1,1,0,0,2'b00,2'b00,0,32'h100));
        edge_step();
        busy = 1'b0;
        chk("br_fire", 0, mk(0,0,1,1,2'b00,2'b00,1,32'h100));
        edge_step();
        chk("br_ex_squashed", 0, mk(0,0,0,0,2'b00,2'b00,0,32'h100));

        // redirect and load-use together
        do_reset();
        id(1, 2, 1, 0, 0, 7, 1, 1);
        chk("brlu_c1", 0, IDLE);
        edge_step();
        id(1, 7, 1, 0, 1, 8, 1, 0);
        pcsel = 2'b10; target = 32'h200;
        chk("brlu_redirect", 0, mk(0,0,1,1,2'b00,2'b00,1,32'h200));

        // stall-only variant: back-to-back dependent add
        do_reset();
        id(1, 1, 1, 2, 1, 5, 1, 0);
        chk("nf_c1", 1, IDLE);
        edge_step();
        id(1, 5, 1, 5, 1, 6, 1, 0);
        chk("nf_stall_ex", 1, mk(1,1,0,1,2'b00,2'b00,0,0));
        edge_step();
        chk("nf_stall_mem", 1, mk(1,1,0,1,2'b00,2'b00,0,0));
        edge_step();
        chk("nf_release", 1, IDLE);

        // async reset in the middle of a stall, with busy raised
        do_reset();
        id(1, 1, 1, 2, 1, 5, 1, 0);
        edge_step();
        id(1, 5, 1, 5, 1, 6, 1, 0);
        chk("nf_rs_stall", 1, mk(1,1,0,1,2'b00,2'b00,0,0));
        rst = 1'b1;
        busy = 1'b1;
        target = 32'h44;
        chk("nf_rs_b", 1, mk(0,0,0,0,2'b00,2'b00,0,32'h44));
        chk("nf_rs_a", 0, mk(0,0,0,0,2'b00,2'b00,0,32'h44));
        edge_step();
        rst = 1'b0;
        busy = 1'b0;
        chk("nf_rs_cleared", 1, mk(0,0,0,0,2'b00,2'b00,0,32'h44));

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

endmodule
